shot_scheduler: RTL and testbench
=================================

// Module: shot_scheduler
// PURPOSE
//   Sequences the tank gun: arbitrates fire requests from mouse and keyboard,
//   issues a one-cycle fire strobe with latched direction to the gun datapath,
//   waits out the bullet flight, then runs a BCD reload countdown for the HUD.
//   Sits between input decoders and the gun controller; also keeps shot/hit tallies.
// PARAMETERS
//   TICK_DIV     650000  clk cycles per 10 ms countdown tick (65 MHz pixel clk)
//   RELOAD_S     5       reload time in whole seconds, 0..9
//   ARM_TIMEOUT  4       cycles after fire to wait for gun_busy to rise
// PORTS
//   clk          in   1   system/pixel clock
//   rst          in   1   asynchronous, active-low reset
//   enable       in   1   game active (tank selected); 0 = new requests ignored
//   req_mouse    in   1   left-click level, requester 0
//   req_key      in   1   fire-key level, requester 1
//   dir_in       in   2   current barrel direction (0 up,1 down,2 left,3 right)
//   gun_busy     in   1   gun datapath has bullet in flight
//   hit          in   1   enemy tank hit pulse/level from gun datapath
//   fire         out  1   one-cycle fire strobe to gun datapath
//   fire_dir     out  2   direction latched at grant, held until next grant
//   grant        out  2   one-hot source of last grant {key,mouse}
//   ready        out  1   1 = IDLE and enable (shot may be taken)
//   reload_sec   out  4   BCD seconds remaining
//   reload_cs    out  8   BCD {tenths,hundredths} remaining
//   shots        out  8   shots fired, saturates at 255
//   hits         out  8   hits scored, saturates at 255
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE, all outputs 0, rr pointer = mouse,
//     edge-detect regs 0, tick counter 0. Reset mid-flight/reload aborts at once.
//   - Edge detect: req_x_d <= req_x each clk; rise_x = req_x & ~req_x_d.
//     Rises outside IDLE or with enable=0 are dropped (no queueing).
//   - FSM: IDLE -> FIRE -> FLIGHT -> RELOAD -> IDLE.
//   - IDLE: if enable and any rise: grant one, latch fire_dir<=dir_in,
//     grant<=one-hot, shots+=1 (sat), go FIRE. Both rise same cycle: grant
//     rr-pointer source; pointer then flips to other source. Single rise:
//     grant it, pointer = the other source.
//   - FIRE: fire=1 for exactly this one cycle (1 clk after rise sampled); -> FLIGHT.
//   - FLIGHT: track seen_busy. Exit to RELOAD when seen_busy and gun_busy=0,
//     or when gun_busy never rose within ARM_TIMEOUT cycles. enable=0 does not abort.
//   - RELOAD entry: reload_sec<=RELOAD_S, reload_cs<=8'h00, tick ctr<=0.
//     tick when ctr==TICK_DIV-1 (ctr wraps to 0). Each tick BCD-decrement:
//     hund>0: hund-1; else tenth>0: tenth-1,hund=9; else sec-1,tenth=9,hund=9.
//     When value is 0.00 on a tick boundary -> IDLE. Total = RELOAD_S*100 ticks.
//     RELOAD_S=0: RELOAD lasts 1 cycle then IDLE.
//   - ready = (state==IDLE) & enable, combinational from registered state.
//   - hits: +1 on rising edge of hit in any state, saturate 255; same-cycle
//     shot and hit both count.
//   - BCD outputs read 0 outside RELOAD.
// TESTING (TICK_DIV=4, RELOAD_S=1, ARM_TIMEOUT=4)
//   - Reset: hold rst=0 w/ requests toggling -> all outputs 0, ready=0 until
//     rst=1 & enable=1, then ready=1.
//   - Single click dir=2: fire=1 one cycle after rise, fire_dir=2, grant=01,
//     shots=1; busy 10 cycles then low -> reload 1.00 counts to 0.00 in
//     400 cycles, ready returns.
//   - Simultaneous rises twice: first grant=01 (mouse), second grant=10 (key).
//   - Click during FLIGHT/RELOAD and with enable=0 -> no fire, shots unchanged.
//   - gun_busy never rises -> RELOAD entered 4 cycles after FIRE.
//   - 256 shots and 256 hit pulses -> shots=255, hits=255; reset mid-RELOAD
//     -> reload_sec/reload_cs=0 immediately, state IDLE.

Source files
------------

// File: rtl/shot_scheduler_if.sv
// shot_scheduler_if
//   Bundles every non-clock/reset signal of the shot scheduler.
//   master : the side that drives requests and gun status (decoders / bench)
//   slave  : the scheduler itself
// Signals
//   enable, req_mouse, req_key, dir_in[1:0], gun_busy, hit   master -> slave
//   fire, fire_dir[1:0], grant[1:0], ready                   slave -> master
//   reload_sec[3:0] (BCD s), reload_cs[7:0] (BCD tenths,hundredths)
//   shots[7:0], hits[7:0] (saturating tallies)
interface shot_scheduler_if;
  logic       enable;
  logic       req_mouse;
  logic       req_key;
  logic [1:0] dir_in;
  logic       gun_busy;
  logic       hit;
  logic       fire;
  logic [1:0] fire_dir;
  logic [1:0] grant;
  logic       ready;
  logic [3:0] reload_sec;
  logic [7:0] reload_cs;
  logic [7:0] shots;
  logic [7:0] hits;

  modport master (
    output enable, req_mouse, req_key, dir_in, gun_busy, hit,
    input  fire, fire_dir, grant, ready, reload_sec, reload_cs, shots, hits
  );

  modport slave (
    input  enable, req_mouse, req_key, dir_in, gun_busy, hit,
    output fire, fire_dir, grant, ready, reload_sec, reload_cs, shots, hits
  );
endinterface

// File: rtl/shot_scheduler.sv
// shot_scheduler
//   Tank gun sequencer. Arbitrates mouse/keyboard fire requests (rising-edge
//   triggered, round-robin on a tie), emits a one-cycle fire strobe with the
//   barrel direction latched at grant, waits for the bullet flight to end,
//   then runs a BCD reload countdown for the HUD. Keeps saturating shot and
//   hit tallies.
// Ports
//   i_clk    : pixel clock
//   i_rst_n  : asynchronous active-low reset (aborts any shot in progress)
//   bus      : shot_scheduler_if.slave (requests, gun status, strobe, HUD)
// Parameters
//   TICK_DIV    : clock cycles per 10 ms countdown tick
//   RELOAD_S    : reload time in whole seconds (0..9)
//   ARM_TIMEOUT : cycles after the fire strobe to wait for gun_busy to rise
module shot_scheduler #(
  parameter int TICK_DIV    = 650000,
  parameter int RELOAD_S    = 5,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  shot_scheduler_if.slave  bus
);

  localparam int CTR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRE   = 2'd1,
    S_FLIGHT = 2'd2,
    S_RELOAD = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_fire;

  logic               r_mouse_d;
  logic               r_key_d;
  logic               r_hit_d;
  logic               r_rr_key;     // 1 = keyboard wins the next tie
  logic [1:0]         r_fire_dir;
  logic [1:0]         r_grant;
  logic [7:0]         r_shots;
  logic [7:0]         r_hits;
  logic               r_seen_busy;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic [CTR_W-1:0]   r_tick_ctr;
  logic [3:0]         r_sec;
  logic [3:0]         r_tenth;
  logic [3:0]         r_hund;

  logic               w_rise_mouse;
  logic               w_rise_key;
  logic               w_rise_hit;
  logic               w_take;
  logic               w_pick_key;
  logic               w_tick;
  logic               w_at_zero;
  logic               w_at_one_cs;
  logic               w_reload_done;
  logic               w_flight_done;
  logic [11:0]        w_bcd_dec;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    r = (v == 8'hFF) ? v : v + 8'd1;
    return r;
  endfunction

  // One hundredth off a {sec,tenth,hund} BCD value; caller guarantees nonzero.
  function automatic logic [11:0] bcd_dec(input logic [3:0] s,
                                          input logic [3:0] t,
                                          input logic [3:0] h);
    logic [11:0] r;
    if (h != 4'd0)      r = {s, t, h - 4'd1};
    else if (t != 4'd0) r = {s, t - 4'd1, 4'd9};
    else                r = {s - 4'd1, 4'd9, 4'd9};
    return r;
  endfunction

  assign w_rise_mouse = bus.req_mouse & ~r_mouse_d;
  assign w_rise_key   = bus.req_key & ~r_key_d;
  assign w_rise_hit   = bus.hit & ~r_hit_d;

  // Rises outside IDLE or while disabled are simply lost.
  assign w_take       = (r_state == S_IDLE) & bus.enable & (w_rise_mouse | w_rise_key);
  assign w_pick_key   = (w_rise_mouse & w_rise_key) ? r_rr_key : w_rise_key;

  assign w_tick        = (r_tick_ctr == CTR_W'(TICK_DIV - 1));
  assign w_at_zero     = (r_sec == 4'd0) & (r_tenth == 4'd0) & (r_hund == 4'd0);
  assign w_at_one_cs   = (r_sec == 4'd0) & (r_tenth == 4'd0) & (r_hund == 4'd1);
  // Leave on the tick that reaches 0.00 so the countdown spans RELOAD_S*100
  // ticks exactly; a zero-length reload leaves after its single cycle.
  assign w_reload_done = w_at_zero | (w_tick & w_at_one_cs);
  // Flight ends once busy has come and gone, or busy never showed up within
  // the arming window (counter is 1 in the first FLIGHT cycle).
  assign w_flight_done = ~bus.gun_busy &
                         (r_seen_busy | (r_arm_cnt == ARM_W'(ARM_TIMEOUT - 1)));
  assign w_bcd_dec     = bcd_dec(r_sec, r_tenth, r_hund);

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_take) w_state_nxt = S_FIRE;
      S_FIRE: begin
        w_fire      = 1'b1;
        w_state_nxt = S_FLIGHT;
      end
      S_FLIGHT: if (w_flight_done) w_state_nxt = S_RELOAD;
      S_RELOAD: if (w_reload_done) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mouse_d   <= 1'b0;
      r_key_d     <= 1'b0;
      r_hit_d     <= 1'b0;
      r_rr_key    <= 1'b0;
      r_fire_dir  <= 2'd0;
      r_grant     <= 2'd0;
      r_shots     <= 8'd0;
      r_hits      <= 8'd0;
      r_seen_busy <= 1'b0;
      r_arm_cnt   <= '0;
      r_tick_ctr  <= '0;
      r_sec       <= 4'd0;
      r_tenth     <= 4'd0;
      r_hund      <= 4'd0;
    end else begin
      r_mouse_d <= bus.req_mouse;
      r_key_d   <= bus.req_key;
      r_hit_d   <= bus.hit;

      if (w_rise_hit) r_hits <= sat_inc8(r_hits);

      if (w_take) begin
        r_fire_dir <= bus.dir_in;
        r_grant    <= w_pick_key ? 2'b10 : 2'b01;
        r_rr_key   <= ~w_pick_key;
        r_shots    <= sat_inc8(r_shots);
      end

      case (r_state)
        S_FIRE: begin
          r_seen_busy <= 1'b0;
          r_arm_cnt   <= ARM_W'(1);
        end
        S_FLIGHT: begin
          if (bus.gun_busy) r_seen_busy <= 1'b1;
          if (r_arm_cnt != ARM_W'(ARM_TIMEOUT - 1)) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
          if (w_flight_done) begin
            r_sec      <= 4'(RELOAD_S);
            r_tenth    <= 4'd0;
            r_hund     <= 4'd0;
            r_tick_ctr <= '0;
          end
        end
        S_RELOAD: begin
          if (w_at_zero) begin
            r_tick_ctr <= '0;
          end else if (w_tick) begin
            r_tick_ctr <= '0;
            {r_sec, r_tenth, r_hund} <= w_bcd_dec;
          end else begin
            r_tick_ctr <= r_tick_ctr + CTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fire       = w_fire;
  assign bus.fire_dir   = r_fire_dir;
  assign bus.grant      = r_grant;
  // Held low while reset is asserted so every output reads 0 in reset.
  assign bus.ready      = (r_state == S_IDLE) & bus.enable & i_rst_n;
  assign bus.reload_sec = (r_state == S_RELOAD) ? r_sec : 4'd0;
  assign bus.reload_cs  = (r_state == S_RELOAD) ? {r_tenth, r_hund} : 8'd0;
  assign bus.shots      = r_shots;
  assign bus.hits       = r_hits;

endmodule

// File: tb/tb_shot_scheduler.sv
// tb_shot_scheduler
//   Drives shot_scheduler (TICK_DIV=4, RELOAD_S=1, ARM_TIMEOUT=4) with directed
//   and random stimulus and compares every cycle against a timestamp-based
//   model of the shot sequence. A second instance with RELOAD_S=0 gives fast
//   shot turnaround for the shot-counter saturation case.
module tb_shot_scheduler;
  localparam int TICK_DIV    = 4;
  localparam int RELOAD_S    = 1;
  localparam int ARM_TIMEOUT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  shot_scheduler_if bus();
  shot_scheduler_if sbus();

  shot_scheduler #(.TICK_DIV(TICK_DIV), .RELOAD_S(RELOAD_S), .ARM_TIMEOUT(ARM_TIMEOUT))
    u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  shot_scheduler #(.TICK_DIV(TICK_DIV), .RELOAD_S(0), .ARM_TIMEOUT(ARM_TIMEOUT))
    u_sat (.i_clk(clk), .i_rst_n(rst_n), .bus(sbus));

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;
  int sat_fires = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // The shot is described by when its strobe cycle happens and when its
  // reload began; the countdown value is derived arithmetically from elapsed
  // cycles rather than stepped digit by digit.
  int m_now = 0;
  bit m_idle = 1'b1;
  int m_fire_at = -10;
  int m_rel_at = -1;
  bit m_seen = 1'b0;
  bit m_pm = 1'b0, m_pk = 1'b0, m_ph = 1'b0, m_ptr_key = 1'b0;
  logic [1:0] m_dir = 2'd0, m_grant = 2'd0;
  int m_shots = 0, m_hits = 0;

  always @(posedge clk or negedge rst_n) begin
    bit rm, rk, pick_key;
    if (!rst_n) begin
      m_idle = 1'b1; m_fire_at = -10; m_rel_at = -1; m_seen = 1'b0;
      m_pm = 1'b0; m_pk = 1'b0; m_ph = 1'b0; m_ptr_key = 1'b0;
      m_dir = 2'd0; m_grant = 2'd0; m_shots = 0; m_hits = 0;
    end else begin
      rm = bus.req_mouse && !m_pm;
      rk = bus.req_key && !m_pk;
      if (m_idle) begin
        if (bus.enable && (rm || rk)) begin
          pick_key  = (rm && rk) ? m_ptr_key : rk;
          m_ptr_key = !pick_key;
          m_grant   = pick_key ? 2'b10 : 2'b01;
          m_dir     = bus.dir_in;
          if (m_shots < 255) m_shots++;
          m_idle = 1'b0; m_fire_at = m_now + 1; m_rel_at = -1; m_seen = 1'b0;
        end
      end else if (m_rel_at < 0) begin
        if (m_now > m_fire_at) begin
          if (!bus.gun_busy && (m_seen || (m_now - m_fire_at == ARM_TIMEOUT - 1)))
            m_rel_at = m_now + 1;
          if (bus.gun_busy) m_seen = 1'b1;
        end
      end else begin
        if (RELOAD_S * 100 - (m_now - m_rel_at + 1) / TICK_DIV <= 0) m_idle = 1'b1;
      end
      if (bus.hit && !m_ph && m_hits < 255) m_hits++;
      m_pm = bus.req_mouse; m_pk = bus.req_key; m_ph = bus.hit;
      m_now++;
    end
  end

  always @(negedge clk) begin
    int rem;
    logic [33:0] e_vec, g_vec;
    logic [3:0] e_sec;
    logic [7:0] e_cs;
    if (run_cmp) begin
      rem = 0;
      if (!m_idle && m_rel_at >= 0 && m_now >= m_rel_at)
        rem = RELOAD_S * 100 - (m_now - m_rel_at) / TICK_DIV;
      e_sec = 4'(rem / 100);
      e_cs  = {4'((rem / 10) % 10), 4'(rem % 10)};
      e_vec = {(!m_idle && m_now == m_fire_at), m_dir, m_grant,
               (rst_n && m_idle && bus.enable), e_sec, e_cs, 8'(m_shots), 8'(m_hits)};
      g_vec = {bus.fire, bus.fire_dir, bus.grant, bus.ready, bus.reload_sec,
               bus.reload_cs, bus.shots, bus.hits};
      check("cycle_model", 64'(g_vec), 64'(e_vec));
    end
  end

  always @(negedge clk) if (sbus.fire === 1'b1) sat_fires++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_ready(input int maxc, output int n);
    n = 0;
    while (!bus.ready && n < maxc) begin tick(1); n++; end
  endtask

  task automatic wait_reload(input int maxc, output int n);
    n = 0;
    while (bus.reload_sec == 4'd0 && bus.reload_cs == 8'd0 && n < maxc) begin tick(1); n++; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.enable = 0; bus.req_mouse = 0; bus.req_key = 0; bus.dir_in = 0;
    bus.gun_busy = 0; bus.hit = 0;
    sbus.enable = 0; sbus.req_mouse = 0; sbus.req_key = 0; sbus.dir_in = 0;
    sbus.gun_busy = 0; sbus.hit = 0;
    #1 rst_n = 1'b0;
    run_cmp = 1'b1;

    // Reset held while inputs toggle
    repeat (6) begin
      tick(1);
      bus.req_mouse = 1'($urandom); bus.req_key = 1'($urandom);
      bus.hit = 1'($urandom); bus.enable = 1'b1;
    end
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_outputs", {bus.fire, bus.grant, bus.fire_dir, bus.shots, bus.hits}, 0);
    bus.req_mouse = 0; bus.req_key = 0; bus.hit = 0; bus.enable = 0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("ready_enable0", bus.ready, 0);
    bus.enable = 1;
    #1 check("ready_enable1", bus.ready, 1);

    // Single click, dir=2, busy for 10 cycles
    tick(1);
    bus.dir_in = 2'd2; bus.req_mouse = 1;
    tick(1);
    check("click_fire", bus.fire, 1);
    check("click_dir", bus.fire_dir, 2);
    check("click_grant", bus.grant, 2'b01);
    check("click_shots", bus.shots, 1);
    bus.gun_busy = 1; bus.req_mouse = 0; bus.dir_in = 2'd0;
    tick(1);
    check("fire_one_cycle", bus.fire, 0);
    tick(2);
    bus.req_mouse = 1;            // rise during FLIGHT: dropped
    tick(1);
    bus.req_mouse = 0;
    tick(6);
    bus.gun_busy = 0;
    wait_reload(20, n);
    check("reload_start", {bus.reload_sec, bus.reload_cs}, 12'h100);
    n = 0;
    while (!bus.ready && n < 1000) begin
      if (n == 50) bus.req_key = 1;   // rise during RELOAD: dropped
      if (n == 51) bus.req_key = 0;
      tick(1); n++;
      if (n == 4) check("reload_0_99", {bus.reload_sec, bus.reload_cs}, 12'h099);
    end
    check("reload_len", n, 400);
    check("reload_end_bcd", {bus.reload_sec, bus.reload_cs}, 0);
    check("no_extra_shots", bus.shots, 1);

    // Click with enable=0
    bus.enable = 0; bus.req_mouse = 1;
    tick(1);
    check("en0_nofire", bus.fire, 0);
    bus.enable = 1;
    tick(3);
    check("en0_shots", bus.shots, 1);
    bus.req_mouse = 0;

    // Simultaneous rises from a fresh reset
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    bus.req_mouse = 1; bus.req_key = 1;
    tick(1);
    check("sim1_fire", bus.fire, 1);
    check("sim1_grant", bus.grant, 2'b01);
    wait_reload(20, n);
    check("arm_timeout", n, 4);
    bus.req_mouse = 0; bus.req_key = 0;
    wait_ready(1000, n);
    check("sim1_ready", bus.ready, 1);
    bus.req_mouse = 1; bus.req_key = 1;
    tick(1);
    check("sim2_grant", bus.grant, 2'b10);
    bus.req_mouse = 0; bus.req_key = 0;
    wait_ready(1000, n);
    check("sim2_ready", bus.ready, 1);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(7) == 0) bus.req_mouse = ~bus.req_mouse;
      if ($urandom_range(7) == 0) bus.req_key = ~bus.req_key;
      bus.dir_in = 2'($urandom_range(3));
      bus.enable = ($urandom_range(15) != 0);
      bus.hit = ($urandom_range(3) == 0);
      if ($urandom_range(5) == 0) bus.gun_busy = ~bus.gun_busy;
      tick(1);
    end
    bus.req_mouse = 0; bus.req_key = 0; bus.hit = 0; bus.gun_busy = 0; bus.enable = 1;
    wait_ready(1000, n);
    check("drain_ready", bus.ready, 1);

    // Hit saturation
    for (int i = 0; i < 256; i++) begin
      bus.hit = 1; tick(1);
      bus.hit = 0; tick(1);
    end
    check("hits_sat", bus.hits, 255);

    // Reset in the middle of RELOAD
    bus.req_mouse = 1;
    tick(1);
    bus.req_mouse = 0;
    wait_reload(20, n);
    tick(20);
    check("reload_mid", {bus.reload_sec, bus.reload_cs}, 12'h095);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_bcd", {bus.reload_sec, bus.reload_cs}, 0);
    check("rst_mid_counts", {bus.shots, bus.hits}, 0);
    check("rst_mid_ready", bus.ready, 0);
    rst_n = 1'b1;
    #1 check("post_rst_ready", bus.ready, 1);

    // Shot saturation on the zero-reload instance
    tick(1);
    sbus.enable = 1;
    for (int i = 0; i < 256; i++) begin
      sbus.req_key = 1; tick(5);
      sbus.req_key = 0; tick(5);
    end
    tick(10);
    check("sat_fires", sat_fires, 256);
    check("shots_sat", sbus.shots, 255);
    check("sat_grant", sbus.grant, 2'b10);
    check("sat_ready", sbus.ready, 1);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
